// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcodes, the D-channel response record and
// the size/address to byte-lane helper.
package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  // Widest source tag a response entry can carry; narrower tags are zero-extended.
  localparam int unsigned SRC_MAX_BITS = 8;

  typedef struct packed {
    logic [2:0]              opcode;
    logic [3:0]              size;
    logic [SRC_MAX_BITS-1:0] source;
    logic                    denied;
    logic [31:0]             data;
    logic                    corrupt;
  } d_resp_t;

  // Byte lanes covered by an access of 2^size bytes at the given word offset.
  function automatic logic [3:0] lane_mask(input logic [3:0] size, input logic [1:0] addr_lo);
    case (size)
      4'd0:    lane_mask = 4'b0001 << addr_lo;
      4'd1:    lane_mask = 4'b0011 << {addr_lo[1], 1'b0};
      4'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/tl_resp_queue.sv
// Two-entry in-order FIFO of D-channel responses with full/empty flags.
module tl_resp_queue
  import tl_ul_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  d_resp_t push_data_i,
  input  logic    pop_i,
  output d_resp_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  d_resp_t    mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL manager backing a small word RAM: single-beat Get/Put, in-order
// D responses through a 2-entry queue, illegal requests answered as denied.
module tl_ul_ram_responder
  import tl_ul_pkg::*;
#(
  parameter int unsigned SOURCE_BITS = 4,
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_param,
  input  logic [3:0]             a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [31:0]            a_address,
  input  logic [3:0]             a_mask,
  input  logic [31:0]            a_data,
  input  logic                   a_corrupt,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [2:0]             d_opcode,
  output logic [1:0]             d_param,
  output logic [3:0]             d_size,
  output logic [SOURCE_BITS-1:0] d_source,
  output logic                   d_sink,
  output logic                   d_denied,
  output logic [31:0]            d_data,
  output logic                   d_corrupt
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned TAG_LO = IDX_W + 2;

  logic [31:0]      mem_q [DEPTH];
  logic [DEPTH-1:0] poison_q;

  logic             a_fire, q_full, q_empty, q_pop;
  logic [IDX_W-1:0] idx;
  logic [3:0]       lanes;
  logic [31:0]      byte_en;
  logic             aligned, in_range, op_ok, mask_ok, legal, is_get, is_put;
  d_resp_t          push_resp, head;
  logic             unused_src;

  assign a_ready = ~q_full;
  assign a_fire  = a_valid & a_ready;
  assign idx     = a_address[TAG_LO-1:2];
  assign lanes   = lane_mask(a_size, a_address[1:0]);
  assign is_get  = (a_opcode == GET);
  assign is_put  = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
  assign op_ok   = is_get || is_put;

  // BASE_ADDR is aligned to the RAM span, so the range test is a tag compare.
  assign in_range = (a_address[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);

  always_comb begin
    case (a_size)
      4'd0:    aligned = 1'b1;
      4'd1:    aligned = ~a_address[0];
      4'd2:    aligned = (a_address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    mask_ok = ((a_mask & ~lanes) == 4'b0000) &&
              ((a_opcode == PUT_PARTIAL) || (a_mask == lanes));
    legal   = op_ok && (a_param == 3'd0) && (a_size <= 4'd2) &&
              aligned && in_range && mask_ok;
    for (int unsigned b = 0; b < 4; b++) byte_en[b*8 +: 8] = {8{a_mask[b]}};
  end

  always_comb begin
    push_resp                         = '0;
    push_resp.opcode                  = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
    push_resp.size                    = a_size;
    push_resp.source[SOURCE_BITS-1:0] = a_source;
    push_resp.denied                  = ~legal;
    if (legal && is_get) begin
      push_resp.data    = mem_q[idx] & byte_en;
      push_resp.corrupt = poison_q[idx];
    end
  end

  // RAM contents deliberately survive reset; only the poison flags clear.
  always_ff @(posedge clock) begin
    if (!reset && a_fire && legal && is_put) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (a_mask[b]) mem_q[idx][b*8 +: 8] <= a_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      poison_q <= '0;
    end else if (a_fire && legal && is_put) begin
      poison_q[idx] <= a_corrupt;
    end
  end

  tl_resp_queue u_queue (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (a_fire),
    .push_data_i (push_resp),
    .pop_i       (q_pop),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign q_pop      = d_valid & d_ready;
  assign d_valid    = ~q_empty;
  assign d_opcode   = q_empty ? '0 : head.opcode;
  assign d_size     = q_empty ? '0 : head.size;
  assign d_source   = q_empty ? '0 : head.source[SOURCE_BITS-1:0];
  assign d_denied   = q_empty ? 1'b0 : head.denied;
  assign d_data     = q_empty ? '0 : head.data;
  assign d_corrupt  = q_empty ? 1'b0 : head.corrupt;
  assign d_param    = '0;
  assign d_sink     = 1'b0;
  assign unused_src = ^head.source;

endmodule
